instruction_fetch_unit: RTL and testbench
=========================================

INSTRUCTION_FETCH_UNIT -- requirements
Module: instruction_fetch_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 32: address and instruction width.
REQ-002 SHALL have parameter DEPTH, default 4: fetch-queue entries, power of two, at least 2.
REQ-003 SHALL have port CLK, input, 1: clock; all state updates on the rising edge.
REQ-004 SHALL have port Reset, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port PC, input, WIDTH: current fetch address from the program counter.
REQ-006 SHALL have port Redirect, input, 1: branch or jump taken; flush all fetch state.
REQ-007 SHALL have port Stall_F, output, 1: drives the program counter's active-low En; 1 holds PC, 0 lets PC load PC_next.
REQ-008 SHALL have ports Imem_req_valid (output, 1), Imem_req_ready (input, 1) and Imem_req_addr (output, WIDTH): instruction-memory request handshake.
REQ-009 SHALL have ports Imem_rsp_valid (input, 1) and Imem_rsp_data (input, WIDTH): instruction-memory response, always in request order.
REQ-010 SHALL have ports Inst_valid (output, 1), Inst_ready (input, 1), Inst (output, WIDTH) and Inst_PC (output, WIDTH): handshake to decode.
REQ-011 SHALL have ports Fetch_cnt (output, 32) and Drop_cnt_o (output, 32): performance counters; see Configuration.

Function
REQ-012 SHALL hold a DEPTH-entry circular queue; each entry holds {pc, data, filled}, with head and tail pointers and an occupancy count 0..DEPTH.
REQ-013 SHALL drive Imem_req_valid = ~Redirect & (count < DEPTH), using the registered count with no same-cycle pop bypass; Imem_req_addr = PC.
REQ-014 SHALL, on a request accept (valid & ready), allocate the entry at tail with pc = PC and filled = 0, and increment tail and count.
REQ-015 SHALL drive Stall_F = ~((Imem_req_valid & Imem_req_ready) | Redirect), so PC advances exactly once per accepted request or redirect.
REQ-016 SHALL, on Imem_rsp_valid when drop_cnt = 0, write data into the oldest unfilled entry and set filled; this needs a fill pointer.
REQ-017 SHALL drive Inst_valid = (count > 0) & head.filled, with Inst = head.data and Inst_PC = head.pc, combinationally from registers.
REQ-018 SHALL, when Inst_valid & Inst_ready, free the head entry: increment head, decrement count.
REQ-019 SHALL apply allocation and pop in the same cycle with count unchanged; a fill and a pop of the same entry in the same cycle is impossible because head must already be filled.
REQ-020 SHALL, on Redirect: clear count, set head = tail = fill pointer, ignore any pop or allocation in that cycle, and set drop_cnt_next = drop_cnt + in_flight - Imem_rsp_valid.
  - in_flight = allocated unfilled entries.
REQ-021 SHALL, on Imem_rsp_valid while drop_cnt > 0 and no Redirect, discard the response and decrement drop_cnt.
REQ-022 SHALL size drop_cnt to hold DEPTH pending discards, which is the maximum possible outstanding.
REQ-023 SHALL wrap pointers modulo DEPTH; full (count = DEPTH) and empty (count = 0) are both distinguished by count.

Reset
REQ-024 SHALL, on Reset low, clear count, head, tail, fill pointer, drop_cnt, all filled bits and both counters immediately, regardless of CLK.
REQ-025 SHALL, during reset, drive Inst_valid = 0 and Imem_req_valid = 0, with Stall_F = 1 unless Redirect is high; the first request after reset release uses the PC value 0x00000000.
REQ-026 SHALL, on reset asserted mid-operation, abandon outstanding responses; the memory is reset by the same Reset.

Configuration
REQ-027 SHALL, with macro FETCH_PERF_CNT_EN defined, implement Fetch_cnt (+1 per decode handshake) and Drop_cnt_o (+1 per discarded response) as free-running 32-bit counters that wrap at 2^32.
REQ-028 SHALL, without FETCH_PERF_CNT_EN, tie Fetch_cnt and Drop_cnt_o to 0 with no counter registers; all other behaviour is identical.

Verification
REQ-029 Reset then PC sequence 0,4,8 with ready=1 and 1-cycle memory latency -> Inst_PC 0,4,8 delivered in order with matching data; Stall_F=0 on each accept.
REQ-030 Inst_ready=0, DEPTH=4, memory always ready -> 4 requests (PC 0..0xC), then Imem_req_valid=0 and Stall_F=1; one pop -> exactly one new request, for PC 0x10.
REQ-031 Redirect with 3 in flight and no response that cycle -> count=0, drop_cnt=3; next 3 responses discarded, Inst_valid=0; 4th response (target PC 0x100) delivered.
REQ-032 Redirect coincident with a response and 2 in flight -> drop_cnt=1; response not written; no request issued that cycle; Stall_F=0.
REQ-033 Reset asserted while 2 requests are outstanding and Inst_valid=1 -> Inst_valid=0 immediately; after release, first Inst_PC = 0x00000000.
REQ-034 With FETCH_PERF_CNT_EN, run REQ-031 -> Drop_cnt_o=3, Fetch_cnt=1 after the target is popped; without the macro -> both read 0.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-fetch bus bundle: instruction-memory request/response channel plus
// the instruction hand-off to decode.
// Ports: Imem_req_* (request handshake), Imem_rsp_* (in-order response, no backpressure),
//        Inst_* (valid/ready hand-off of {Inst, Inst_PC} to decode).
// master = fetch unit side, slave = memory/decode side.
interface instruction_fetch_unit_if #(
   parameter int WIDTH = 32
);
   logic             Imem_req_valid;
   logic             Imem_req_ready;
   logic [WIDTH-1:0] Imem_req_addr;
   logic             Imem_rsp_valid;
   logic [WIDTH-1:0] Imem_rsp_data;
   logic             Inst_valid;
   logic             Inst_ready;
   logic [WIDTH-1:0] Inst;
   logic [WIDTH-1:0] Inst_PC;

   modport master (
      output Imem_req_valid, Imem_req_addr,
      input  Imem_req_ready,
      input  Imem_rsp_valid, Imem_rsp_data,
      output Inst_valid, Inst, Inst_PC,
      input  Inst_ready
   );

   modport slave (
      input  Imem_req_valid, Imem_req_addr,
      output Imem_req_ready,
      output Imem_rsp_valid, Imem_rsp_data,
      input  Inst_valid, Inst, Inst_PC,
      output Inst_ready
   );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: issues PC requests to instruction memory, queues responses in
//   request order and hands {Inst, Inst_PC} to decode; flushes and discards stale responses on Redirect.
// Latency: instruction visible to decode the cycle after its response arrives; outputs come straight from registers.
// Backpressure: Inst_ready low holds the queue; a full queue (count = DEPTH) stops requests and stalls the PC.
// Ports: CLK, Reset (async, active-low), PC/Redirect from the PC stage, Stall_F to the PC enable,
//   bus (instruction_fetch_unit_if.master), Fetch_cnt/Drop_cnt_o performance counters.
// Optional macro FETCH_PERF_CNT_EN enables the performance counters (otherwise tied to zero).
module instruction_fetch_unit #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     Reset,
   input  logic [WIDTH-1:0]         PC,
   input  logic                     Redirect,
   output logic                     Stall_F,
   instruction_fetch_unit_if.master bus,
   output logic [31:0]              Fetch_cnt,
   output logic [31:0]              Drop_cnt_o
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
   localparam logic [CW-1:0] CONE    = CW'(1);
   localparam logic [PW-1:0] PONE    = PW'(1);

   logic [WIDTH-1:0] r_pc   [DEPTH];
   logic [WIDTH-1:0] r_data [DEPTH];
   logic [DEPTH-1:0] r_filled;
   logic [PW-1:0]    r_head;
   logic [PW-1:0]    r_tail;
   logic [PW-1:0]    r_fill;
   logic [CW-1:0]    r_count;
   logic [CW-1:0]    r_inflight;   // allocated entries still waiting for their response
   logic [CW-1:0]    r_drop;       // responses still owed to flushed requests

   logic w_req_vld;
   logic w_alloc;
   logic w_inst_vld;
   logic w_pop;
   logic w_rsp_fill;
   logic w_rsp_drop;

   // Request gating uses the registered count only: a pop this cycle frees space next cycle.
   assign w_req_vld  = Reset & ~Redirect & (r_count < DEPTH_C);
   assign w_alloc    = w_req_vld & bus.Imem_req_ready;
   assign w_inst_vld = (r_count != '0) & r_filled[r_head];
   assign w_pop      = w_inst_vld & bus.Inst_ready & ~Redirect;
   assign w_rsp_fill = bus.Imem_rsp_valid & (r_drop == '0) & ~Redirect;
   assign w_rsp_drop = bus.Imem_rsp_valid & ~w_rsp_fill;

   assign Stall_F            = ~(w_alloc | Redirect);
   assign bus.Imem_req_valid = w_req_vld;
   assign bus.Imem_req_addr  = PC;
   assign bus.Inst_valid     = w_inst_vld;
   assign bus.Inst           = r_data[r_head];
   assign bus.Inst_PC        = r_pc[r_head];

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_filled   <= '0;
         r_head     <= '0;
         r_tail     <= '0;
         r_fill     <= '0;
         r_count    <= '0;
         r_inflight <= '0;
         r_drop     <= '0;
      end else if (Redirect) begin
         // Every unanswered request becomes a pending discard; a response arriving
         // this same cycle is itself discarded, so it is taken off the total.
         r_count    <= '0;
         r_head     <= r_tail;
         r_fill     <= r_tail;
         r_inflight <= '0;
         r_drop     <= r_drop + r_inflight - CW'(bus.Imem_rsp_valid);
      end else begin
         // Allocation clears tail's filled bit while a fill sets fill's bit; the two
         // indices can only coincide when the queue is full or nothing is in flight,
         // and in neither case do both events happen together.
         if (w_alloc) begin
            r_tail           <= r_tail + PONE;
            r_filled[r_tail] <= 1'b0;
         end
         if (w_rsp_fill) begin
            r_filled[r_fill] <= 1'b1;
            r_fill           <= r_fill + PONE;
         end
         if (w_pop) begin
            r_head <= r_head + PONE;
         end
         case ({w_alloc, w_pop})
            2'b10:   r_count <= r_count + CONE;
            2'b01:   r_count <= r_count - CONE;
            default: r_count <= r_count;
         endcase
         case ({w_alloc, w_rsp_fill})
            2'b10:   r_inflight <= r_inflight + CONE;
            2'b01:   r_inflight <= r_inflight - CONE;
            default: r_inflight <= r_inflight;
         endcase
         if (w_rsp_drop) begin
            r_drop <= r_drop - CONE;
         end
      end
   end

   // Payload storage carries no reset: entries are only read once marked filled.
   always_ff @(posedge CLK) begin
      if (w_alloc) begin
         r_pc[r_tail] <= PC;
      end
      if (w_rsp_fill) begin
         r_data[r_fill] <= bus.Imem_rsp_data;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_fetch_cnt;
   logic [31:0] r_drop_cnt;

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         r_fetch_cnt <= '0;
         r_drop_cnt  <= '0;
      end else begin
         if (w_pop) begin
            r_fetch_cnt <= r_fetch_cnt + 32'd1;
         end
         if (w_rsp_drop) begin
            r_drop_cnt <= r_drop_cnt + 32'd1;
         end
      end
   end

   assign Fetch_cnt  = r_fetch_cnt;
   assign Drop_cnt_o = r_drop_cnt;
`else
   assign Fetch_cnt  = 32'd0;
   assign Drop_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Testbench for instruction_fetch_unit: in-order memory model with random latency and
// a queue-based reference of what decode should receive.
module tb_instruction_fetch_unit;
   localparam int WIDTH = 32;
   localparam int DEPTH = 4;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic [31:0] PC = 32'h0;
   logic        Redirect = 1'b0;
   wire         Stall_F;
   wire  [31:0] Fetch_cnt;
   wire  [31:0] Drop_cnt_o;

   instruction_fetch_unit_if #(.WIDTH(WIDTH)) bus ();

   instruction_fetch_unit #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .PC         (PC),
      .Redirect   (Redirect),
      .Stall_F    (Stall_F),
      .bus        (bus.master),
      .Fetch_cnt  (Fetch_cnt),
      .Drop_cnt_o (Drop_cnt_o)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int failures = 0;

   int mem_rdy_pct, rsp_pct, irdy_pct, redir_pct;
   logic [31:0] redir_tgt;

   // Reference: PCs owed to decode in order, how many of those have data, and the
   // memory's outstanding requests tagged live/stale.
   logic [31:0] exp_pc[$];
   int          exp_filled;
   logic [31:0] mem_addr[$];
   bit          mem_live[$];
   int          m_fetch, m_drop;

   function automatic logic [31:0] memfn(input logic [31:0] a);
      return (a * 32'h9E3779B1) ^ 32'h1357_2468;
   endfunction

   function automatic bit roll(input int pct);
      return int'($urandom_range(0, 99)) < pct;
   endfunction

   task automatic reset_model();
      exp_pc.delete();
      mem_addr.delete();
      mem_live.delete();
      exp_filled = 0;
      m_fetch = 0;
      m_drop = 0;
   endtask

   task automatic drive_next();
      Redirect = roll(redir_pct);
      if (Redirect) redir_tgt = $urandom() & 32'hFFFF_FFFC;
      bus.Inst_ready     = roll(irdy_pct);
      bus.Imem_req_ready = (mem_addr.size() < DEPTH) && roll(mem_rdy_pct);
      bus.Imem_rsp_valid = (mem_addr.size() > 0) && roll(rsp_pct);
      bus.Imem_rsp_data  = 32'h0;
      if (mem_addr.size() > 0) bus.Imem_rsp_data = memfn(mem_addr[0]);
   endtask

   // One clock: apply the model's view of the current inputs, then draw the next inputs.
   task automatic step(output bit acc, output bit pop);
      bit rsp, live;
      logic [31:0] nxt_pc;
      acc = Reset && !Redirect && (exp_pc.size() < DEPTH) && bus.Imem_req_ready;
      pop = (exp_filled > 0) && bus.Inst_ready && !Redirect;
      rsp = bus.Imem_rsp_valid;
      nxt_pc = PC;
      @(posedge CLK);
      if (rsp) begin
         live = mem_live.pop_front();
         void'(mem_addr.pop_front());
         if (live && !Redirect) exp_filled++;
         else m_drop++;
      end
      if (Redirect) begin
         exp_pc.delete();
         exp_filled = 0;
         foreach (mem_live[i]) mem_live[i] = 1'b0;
         nxt_pc = redir_tgt;
      end else begin
         if (pop) begin
            void'(exp_pc.pop_front());
            exp_filled--;
            m_fetch++;
         end
         if (acc) begin
            exp_pc.push_back(PC);
            mem_addr.push_back(PC);
            mem_live.push_back(1'b1);
            nxt_pc = PC + 32'd4;
         end
      end
      @(negedge CLK);
      PC = nxt_pc;
      drive_next();
   endtask

   task automatic do_reset();
      Reset = 1'b0;
      Redirect = 1'b0;
      PC = 32'h0;
      bus.Imem_req_ready = 1'b0;
      bus.Imem_rsp_valid = 1'b0;
      bus.Imem_rsp_data = 32'h0;
      bus.Inst_ready = 1'b0;
      mem_rdy_pct = 0; rsp_pct = 0; irdy_pct = 0; redir_pct = 0;
      reset_model();
      repeat (2) @(negedge CLK);
      Reset = 1'b1;
   endtask

   task automatic test_reset();
      Reset = 1'b0;
      Redirect = 1'b0;
      bus.Imem_req_ready = 1'b1;
      bus.Imem_rsp_valid = 1'b0;
      bus.Inst_ready = 1'b1;
      @(negedge CLK);
      checks++; if (bus.Inst_valid !== 1'b0) begin failures++; $display("FAIL reset_inst_valid got=%b exp=0", bus.Inst_valid); end
      checks++; if (bus.Imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_req_valid got=%b exp=0", bus.Imem_req_valid); end
      checks++; if (Stall_F !== 1'b1) begin failures++; $display("FAIL reset_stall got=%b exp=1", Stall_F); end
      checks++; if (Fetch_cnt !== 32'd0) begin failures++; $display("FAIL reset_fetch_cnt got=%0d exp=0", Fetch_cnt); end
      checks++; if (Drop_cnt_o !== 32'd0) begin failures++; $display("FAIL reset_drop_cnt got=%0d exp=0", Drop_cnt_o); end
      Redirect = 1'b1;
      #1;
      checks++; if (Stall_F !== 1'b0) begin failures++; $display("FAIL reset_redirect_stall got=%b exp=0", Stall_F); end
      checks++; if (bus.Imem_req_valid !== 1'b0) begin failures++; $display("FAIL reset_redirect_req got=%b exp=0", bus.Imem_req_valid); end
      Redirect = 1'b0;
   endtask

   task automatic test_in_order();
      bit acc, pop;
      int nacc = 0, npop = 0;
      do_reset();
      mem_rdy_pct = 100; rsp_pct = 100; irdy_pct = 100;
      drive_next();
      for (int c = 0; c < 20; c++) begin
         if (nacc >= 3) bus.Imem_req_ready = 1'b0;
         #1;
         if ((exp_pc.size() < DEPTH) && bus.Imem_req_ready) begin
            checks++;
            if (Stall_F !== 1'b0 || bus.Imem_req_addr !== 32'(4 * nacc)) begin
               failures++; $display("FAIL inorder_accept stall=%b addr=%h exp_addr=%h", Stall_F, bus.Imem_req_addr, 32'(4 * nacc));
            end
         end
         if (bus.Inst_valid && bus.Inst_ready) begin
            checks++;
            if (bus.Inst_PC !== 32'(4 * npop) || bus.Inst !== memfn(32'(4 * npop))) begin
               failures++; $display("FAIL inorder_pop pc=%h inst=%h exp_pc=%h", bus.Inst_PC, bus.Inst, 32'(4 * npop));
            end
            npop++;
         end
         step(acc, pop);
         if (acc) nacc++;
      end
      checks++; if (npop != 3) begin failures++; $display("FAIL inorder_count got=%0d exp=3", npop); end
   endtask

   task automatic test_full();
      bit acc, pop;
      int nacc = 0;
      do_reset();
      mem_rdy_pct = 100; rsp_pct = 100; irdy_pct = 0;
      drive_next();
      for (int c = 0; c < 10; c++) begin
         #1;
         if ((exp_pc.size() < DEPTH) && bus.Imem_req_ready) begin
            checks++;
            if (bus.Imem_req_valid !== 1'b1 || Stall_F !== 1'b0 || bus.Imem_req_addr !== 32'(4 * nacc)) begin
               failures++; $display("FAIL full_fill_req vld=%b stall=%b addr=%h", bus.Imem_req_valid, Stall_F, bus.Imem_req_addr);
            end
         end
         step(acc, pop);
         if (acc) nacc++;
      end
      #1;
      checks++; if (nacc != 4) begin failures++; $display("FAIL full_accepts got=%0d exp=4", nacc); end
      checks++; if (bus.Imem_req_valid !== 1'b0 || Stall_F !== 1'b1) begin
         failures++; $display("FAIL full_hold vld=%b stall=%b exp vld=0 stall=1", bus.Imem_req_valid, Stall_F);
      end
      bus.Inst_ready = 1'b1;
      #1;
      checks++; if (bus.Inst_valid !== 1'b1 || bus.Inst_PC !== 32'h0 || bus.Imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL full_pop vld=%b pc=%h req=%b", bus.Inst_valid, bus.Inst_PC, bus.Imem_req_valid);
      end
      step(acc, pop);
      nacc = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if ((exp_pc.size() < DEPTH) && bus.Imem_req_ready) begin
            checks++;
            if (bus.Imem_req_valid !== 1'b1 || bus.Imem_req_addr !== 32'h10) begin
               failures++; $display("FAIL full_refill vld=%b addr=%h exp=00000010", bus.Imem_req_valid, bus.Imem_req_addr);
            end
         end
         step(acc, pop);
         if (acc) nacc++;
      end
      checks++; if (nacc != 1) begin failures++; $display("FAIL full_refill_count got=%0d exp=1", nacc); end
   endtask

   task automatic test_redirect_drop();
      bit acc, pop;
      int nacc = 0, npop = 0;
      do_reset();
      mem_rdy_pct = 100; rsp_pct = 0; irdy_pct = 0;
      drive_next();
      repeat (3) step(acc, pop);
      Redirect = 1'b1;
      redir_tgt = 32'h100;
      bus.Imem_rsp_valid = 1'b0;
      #1;
      checks++; if (Stall_F !== 1'b0 || bus.Imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL drop3_redirect stall=%b req=%b exp 0/0", Stall_F, bus.Imem_req_valid);
      end
      rsp_pct = 100; irdy_pct = 100;
      step(acc, pop);
      for (int c = 0; c < 20; c++) begin
         if (nacc >= 1) bus.Imem_req_ready = 1'b0;
         #1;
         checks++; if (bus.Inst_valid !== (exp_filled > 0)) begin
            failures++; $display("FAIL drop3_inst_valid got=%b exp=%b", bus.Inst_valid, exp_filled > 0);
         end
         if (bus.Inst_valid && bus.Inst_ready) begin
            checks++;
            if (bus.Inst_PC !== 32'h100 || bus.Inst !== memfn(32'h100)) begin
               failures++; $display("FAIL drop3_target pc=%h inst=%h exp_pc=00000100", bus.Inst_PC, bus.Inst);
            end
            npop++;
         end
         step(acc, pop);
         if (acc) nacc++;
      end
      checks++; if (npop != 1) begin failures++; $display("FAIL drop3_pops got=%0d exp=1", npop); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (Drop_cnt_o !== 32'd3 || Fetch_cnt !== 32'd1) begin
         failures++; $display("FAIL drop3_counters drop=%0d fetch=%0d exp 3/1", Drop_cnt_o, Fetch_cnt);
      end
`else
      checks++; if (Drop_cnt_o !== 32'd0 || Fetch_cnt !== 32'd0) begin
         failures++; $display("FAIL drop3_counters drop=%0d fetch=%0d exp 0/0", Drop_cnt_o, Fetch_cnt);
      end
`endif
   endtask

   task automatic test_redirect_rsp();
      bit acc, pop;
      int nacc = 0, npop = 0;
      do_reset();
      mem_rdy_pct = 100; rsp_pct = 0; irdy_pct = 0;
      drive_next();
      repeat (2) step(acc, pop);
      Redirect = 1'b1;
      redir_tgt = 32'h200;
      bus.Imem_rsp_valid = 1'b1;
      bus.Imem_rsp_data = memfn(mem_addr[0]);
      #1;
      checks++; if (Stall_F !== 1'b0 || bus.Imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL rsp_redirect stall=%b req=%b exp 0/0", Stall_F, bus.Imem_req_valid);
      end
      rsp_pct = 100; irdy_pct = 100;
      step(acc, pop);
      #1;
      checks++; if (bus.Inst_valid !== 1'b0) begin failures++; $display("FAIL rsp_not_written got=%b exp=0", bus.Inst_valid); end
      for (int c = 0; c < 20; c++) begin
         if (nacc >= 1) bus.Imem_req_ready = 1'b0;
         #1;
         if (bus.Inst_valid && bus.Inst_ready) begin
            checks++;
            if (bus.Inst_PC !== 32'h200 || bus.Inst !== memfn(32'h200)) begin
               failures++; $display("FAIL rsp_target pc=%h inst=%h exp_pc=00000200", bus.Inst_PC, bus.Inst);
            end
            npop++;
         end
         step(acc, pop);
         if (acc) nacc++;
      end
      checks++; if (npop != 1) begin failures++; $display("FAIL rsp_pops got=%0d exp=1", npop); end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (Drop_cnt_o !== 32'd2) begin failures++; $display("FAIL rsp_drop_cnt got=%0d exp=2", Drop_cnt_o); end
`endif
   endtask

   task automatic test_reset_mid();
      bit acc, pop;
      int npop = 0;
      do_reset();
      mem_rdy_pct = 100; rsp_pct = 0; irdy_pct = 0;
      drive_next();
      step(acc, pop);
      bus.Imem_rsp_valid = 1'b1;
      bus.Imem_rsp_data = memfn(mem_addr[0]);
      step(acc, pop);
      step(acc, pop);
      #1;
      checks++; if (bus.Inst_valid !== 1'b1) begin failures++; $display("FAIL midreset_pre got=%b exp=1", bus.Inst_valid); end
      #1;
      Reset = 1'b0;
      #1;
      checks++; if (bus.Inst_valid !== 1'b0 || bus.Imem_req_valid !== 1'b0) begin
         failures++; $display("FAIL midreset_async inst_vld=%b req_vld=%b exp 0/0", bus.Inst_valid, bus.Imem_req_valid);
      end
      reset_model();
      PC = 32'h0;
      @(negedge CLK);
      Reset = 1'b1;
      mem_rdy_pct = 100; rsp_pct = 100; irdy_pct = 100;
      drive_next();
      for (int c = 0; c < 20 && npop == 0; c++) begin
         #1;
         if (bus.Inst_valid && bus.Inst_ready) begin
            checks++;
            if (bus.Inst_PC !== 32'h0 || bus.Inst !== memfn(32'h0)) begin
               failures++; $display("FAIL midreset_first pc=%h inst=%h exp_pc=00000000", bus.Inst_PC, bus.Inst);
            end
            npop++;
         end
         step(acc, pop);
      end
      checks++; if (npop != 1) begin failures++; $display("FAIL midreset_timeout pops=%0d exp=1", npop); end
   endtask

   task automatic test_random();
      bit acc, pop, exp_req;
      do_reset();
      mem_rdy_pct = 70; rsp_pct = 60; irdy_pct = 60; redir_pct = 5;
      drive_next();
      for (int c = 0; c < 3000 && failures < 20; c++) begin
         #1;
         exp_req = !Redirect && (exp_pc.size() < DEPTH);
         checks++; if (bus.Imem_req_valid !== exp_req || bus.Imem_req_addr !== PC) begin
            failures++; $display("FAIL rand_req cyc=%0d vld=%b exp=%b addr=%h", c, bus.Imem_req_valid, exp_req, bus.Imem_req_addr);
         end
         checks++; if (Stall_F !== !((exp_req && bus.Imem_req_ready) || Redirect)) begin
            failures++; $display("FAIL rand_stall cyc=%0d got=%b", c, Stall_F);
         end
         checks++; if (bus.Inst_valid !== (exp_filled > 0)) begin
            failures++; $display("FAIL rand_inst_valid cyc=%0d got=%b exp=%b", c, bus.Inst_valid, exp_filled > 0);
         end
         if (exp_filled > 0) begin
            checks++; if (bus.Inst_PC !== exp_pc[0] || bus.Inst !== memfn(exp_pc[0])) begin
               failures++; $display("FAIL rand_inst cyc=%0d pc=%h exp_pc=%h inst=%h", c, bus.Inst_PC, exp_pc[0], bus.Inst);
            end
         end
         step(acc, pop);
      end
`ifdef FETCH_PERF_CNT_EN
      checks++; if (Fetch_cnt !== 32'(m_fetch) || Drop_cnt_o !== 32'(m_drop)) begin
         failures++; $display("FAIL rand_counters fetch=%0d exp=%0d drop=%0d exp=%0d", Fetch_cnt, m_fetch, Drop_cnt_o, m_drop);
      end
`else
      checks++; if (Fetch_cnt !== 32'd0 || Drop_cnt_o !== 32'd0) begin
         failures++; $display("FAIL rand_counters fetch=%0d drop=%0d exp 0/0", Fetch_cnt, Drop_cnt_o);
      end
`endif
   endtask

   initial begin
      bus.Imem_req_ready = 1'b0;
      bus.Imem_rsp_valid = 1'b0;
      bus.Imem_rsp_data = 32'h0;
      bus.Inst_ready = 1'b0;
      redir_tgt = 32'h0;
      mem_rdy_pct = 0; rsp_pct = 0; irdy_pct = 0; redir_pct = 0;
      reset_model();
      test_reset();
      test_in_order();
      test_full();
      test_redirect_drop();
      test_redirect_rsp();
      test_reset_mid();
      test_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
